// File: rtl/store_split.sv
// Store-alignment unit: lane-shifts one store request onto the data bus as one
// or two beats, or reports an alignment fault, then pulses done.
package store_split_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module store_split
  import store_split_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  msize_t            req_size,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic              done,
  output logic              exc
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       data_reg;
  msize_t            size_reg;
  logic              fault_reg;
  logic              split_reg;

  // Request classification, evaluated only on the accepting edge
  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_n;
  logic [4:0]       req_end;
  logic             req_fault;
  logic             req_split;
  logic             accept;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_n     = 4'd1 << req_size;
  assign req_end   = 5'(req_off) + 5'(req_n);
  assign req_fault = (5'(req_n) > 5'(BYTES)) ||
                     ((ALLOW_MISALIGN == 0) && ((4'(req_off) & (req_n - 4'd1)) != 4'd0));
  assign req_split = (req_end > 5'(BYTES));
  assign accept    = req_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      size_reg  <= MSIZE1;
      fault_reg <= 1'b0;
      split_reg <= 1'b0;
    end else if (accept) begin
      addr_reg  <= req_addr;
      data_reg  <= req_data;
      size_reg  <= req_size;
      fault_reg <= req_fault;
      split_reg <= req_split && !req_fault;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = req_fault ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          state_next = split_reg ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane shifter works from the captured request so outputs never see req_*
  logic [OFF_W-1:0]    off;
  logic [63:0]         data_mask;
  logic [2*DATA_W-1:0] masked_wide;
  logic [2*DATA_W-1:0] wide_data;
  logic [2*BYTES-1:0]  strb_base;
  logic [2*BYTES-1:0]  wide_strb;
  logic [ADDR_W-1:0]   aligned_addr;
  logic [ADDR_W-1:0]   upper_addr;

  assign off          = addr_reg[OFF_W-1:0];
  assign aligned_addr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign upper_addr   = aligned_addr + ADDR_W'(BYTES);

  always_comb begin
    data_mask = '1;
    strb_base = '0;
    case (size_reg)
      MSIZE1: begin
        data_mask      = 64'h0000_0000_0000_00FF;
        strb_base[7:0] = 8'h01;
      end
      MSIZE2: begin
        data_mask      = 64'h0000_0000_0000_FFFF;
        strb_base[7:0] = 8'h03;
      end
      MSIZE4: begin
        data_mask      = 64'h0000_0000_FFFF_FFFF;
        strb_base[7:0] = 8'h0F;
      end
      default: begin
        data_mask      = 64'hFFFF_FFFF_FFFF_FFFF;
        strb_base[7:0] = 8'hFF;
      end
    endcase
  end

  always_comb begin
    masked_wide        = '0;
    masked_wide[63:0]  = data_reg & data_mask;
  end

  assign wide_data = masked_wide << {off, 3'b000};
  assign wide_strb = strb_base << off;

  logic [DATA_W-1:0] beat_data;
  logic [BYTES-1:0]  beat_strb;

  always_comb begin
    req_ready = 1'b0;
    bus_valid = 1'b0;
    bus_addr  = '0;
    beat_data = '0;
    beat_strb = '0;
    done      = 1'b0;
    exc       = 1'b0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      BEAT0: begin
        bus_valid = 1'b1;
        bus_addr  = aligned_addr;
        beat_data = wide_data[DATA_W-1:0];
        beat_strb = wide_strb[BYTES-1:0];
      end
      BEAT1: begin
        bus_valid = 1'b1;
        bus_addr  = upper_addr;
        beat_data = wide_data[2*DATA_W-1:DATA_W];
        beat_strb = wide_strb[2*BYTES-1:BYTES];
      end
      RESP: begin
        done = 1'b1;
        exc  = fault_reg;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Disabled lanes are forced to zero regardless of the shifter contents
  assign bus_strobe = beat_strb;
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign bus_data[gi*8 +: 8] = beat_data[gi*8 +: 8] & {8{beat_strb[gi]}};
    end
  endgenerate

endmodule

// File: tb/tb_store_split.sv
// Self-checking bench for store_split: vector table plus hand-written
// backpressure, fault and reset sequences, with a beat scoreboard.
module tb_store_split;
  import store_split_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  msize_t      req_size = MSIZE1;
  logic        bus_valid;
  logic        bus_ready = 1'b1;
  logic [63:0] bus_addr;
  logic [63:0] bus_data;
  logic [7:0]  bus_strobe;
  logic        done;
  logic        exc;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [63:0] s_req_addr = '0;
  logic [63:0] s_req_data = '0;
  msize_t      s_req_size = MSIZE1;
  logic        s_bus_valid;
  logic        s_bus_ready = 1'b1;
  logic [63:0] s_bus_addr;
  logic [63:0] s_bus_data;
  logic [7:0]  s_bus_strobe;
  logic        s_done;
  logic        s_exc;

  always #5 clk = ~clk;

  store_split #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_strobe(bus_strobe),
    .done(done), .exc(exc)
  );

  store_split #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(0)) dut_strict (
    .clk(clk), .resetn(resetn),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr),
    .req_data(s_req_data), .req_size(s_req_size),
    .bus_valid(s_bus_valid), .bus_ready(s_bus_ready), .bus_addr(s_bus_addr),
    .bus_data(s_bus_data), .bus_strobe(s_bus_strobe),
    .done(s_done), .exc(s_exc)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    msize_t      size;
    int          nbeats;
    logic [63:0] a0;
    logic [63:0] d0;
    logic [7:0]  s0;
    logic [63:0] a1;
    logic [63:0] d1;
    logic [7:0]  s1;
    int          done_cyc;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  vec_t  vecs[8];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    strict_valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed beat handshake must match the oldest expectation
  always @(negedge clk) begin
    if (resetn && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_addr", bus_addr, 64'hFFFF_FFFF_FFFF_FFFF ^ bus_addr);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_addr", bus_addr, b.addr);
        check("beat_data", bus_data, b.data);
        check("beat_strobe", 64'(bus_strobe), 64'(b.strb));
        $display("beat addr=0x%h data=0x%h strobe=0x%h", bus_addr, bus_data, bus_strobe);
      end
    end
    if (s_bus_valid) strict_valid_cycles++;
  end

  task automatic run_vec(input vec_t v);
    int got_cyc;
    logic got_exc;
    got_cyc = -1;
    got_exc = 1'b0;
    exp_q.push_back('{v.a0, v.d0, v.s0});
    if (v.nbeats == 2) exp_q.push_back('{v.a1, v.d1, v.s1});
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        got_cyc = c;
        got_exc = exc;
        check("ready_low_in_resp", 64'(req_ready), 64'd0);
        break;
      end
    end
    check("done_cycle", 64'(got_cyc), 64'(v.done_cyc));
    check("exc_clear", 64'(got_exc), 64'd0);
    @(negedge clk);
    check("done_one_pulse", 64'(done), 64'd0);
    check("ready_after_resp", 64'(req_ready), 64'd1);
    $display("store addr=0x%h size=%0d beats=%0d done_cycle=%0d exc=%0b",
             v.addr, v.size, v.nbeats, got_cyc, got_exc);
  endtask

  task automatic run_strict_fault(input logic [63:0] a, input msize_t s);
    @(posedge clk); #1;
    s_req_valid = 1'b1; s_req_addr = a; s_req_data = 64'h55AA; s_req_size = s;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    check("fault_done_c1", 64'(s_done), 64'd1);
    check("fault_exc_c1", 64'(s_exc), 64'd1);
    @(negedge clk);
    check("fault_ready_c2", 64'(s_req_ready), 64'd1);
    check("fault_done_c2", 64'(s_done), 64'd0);
    $display("fault store addr=0x%h size=%0d", a, s);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{64'h1005, 64'hAB, MSIZE1, 1,
                64'h1000, 64'h0000_AB00_0000_0000, 8'h20, 64'h0, 64'h0, 8'h00, 2};
    vecs[1] = '{64'h2006, 64'h8877_6655_4433_2211, MSIZE8, 2,
                64'h2000, 64'h2211_0000_0000_0000, 8'hC0,
                64'h2008, 64'h0000_8877_6655_4433, 8'h3F, 3};
    vecs[2] = '{64'h4002, 64'hDEAD_BEEF, MSIZE4, 1,
                64'h4000, 64'h0000_DEAD_BEEF_0000, 8'h3C, 64'h0, 64'h0, 8'h00, 2};
    vecs[3] = '{64'h8000, 64'h0123_4567_89AB_CDEF, MSIZE8, 1,
                64'h8000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h0, 8'h00, 2};
    vecs[4] = '{64'h7, 64'hFFFF_1234, MSIZE2, 2,
                64'h0, 64'h3400_0000_0000_0000, 8'h80,
                64'h8, 64'h12, 8'h01, 3};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1122_3344_5566_7788, MSIZE8, 2,
                64'hFFFF_FFFF_FFFF_FFF8, 64'h5566_7788_0000_0000, 8'hF0,
                64'h0, 64'h1122_3344, 8'h0F, 3};
    vecs[6] = '{64'h10, 64'hAAAA_AAAA_CAFE_F00D, MSIZE4, 1,
                64'h10, 64'h0000_0000_CAFE_F00D, 8'h0F, 64'h0, 64'h0, 8'h00, 2};
    vecs[7] = '{64'h0, 64'hFFFF_FFFF_FFFF_FF5A, MSIZE1, 1,
                64'h0, 64'h5A, 8'h01, 64'h0, 64'h0, 8'h00, 2};

    #2;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_exc", 64'(exc), 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_bus_strobe", 64'(bus_strobe), 64'd0);
    check("rst_strict_ready", 64'(s_req_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: beat0 of the split store held for three cycles
    bus_ready = 1'b0;
    exp_q.push_back('{vecs[1].a0, vecs[1].d0, vecs[1].s0});
    exp_q.push_back('{vecs[1].a1, vecs[1].d1, vecs[1].s1});
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = vecs[1].addr; req_data = vecs[1].data; req_size = vecs[1].size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus_valid), 64'd1);
      check("bp_addr", bus_addr, vecs[1].a0);
      check("bp_data", bus_data, vecs[1].d0);
      check("bp_strobe", 64'(bus_strobe), 64'(vecs[1].s0));
      check("bp_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    bus_ready = 1'b1;
    cyc = -1;
    for (int c = 4; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
    check("bp_done_cycle", 64'(cyc), 64'd6);
    $display("backpressure store addr=0x%h done_cycle=%0d", vecs[1].addr, cyc);

    run_strict_fault(64'h3001, MSIZE2);
    run_strict_fault(64'h3004, MSIZE8);

    // Reset while the split store sits in BEAT1
    exp_q.push_back('{vecs[1].a0, vecs[1].d0, vecs[1].s0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = vecs[1].addr; req_data = vecs[1].data; req_size = vecs[1].size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    #2;
    check("rs_in_beat1_valid", 64'(bus_valid), 64'd1);
    check("rs_in_beat1_addr", bus_addr, vecs[1].a1);
    resetn = 1'b0;
    #1;
    check("rs_async_valid", 64'(bus_valid), 64'd0);
    check("rs_async_addr", bus_addr, 64'd0);
    check("rs_async_done", 64'(done), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rs_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    check("rs_ready_after", 64'(req_ready), 64'd1);
    check("rs_no_done_after", 64'(done), 64'd0);
    $display("reset during split, recovery follows");
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("strict_no_beat", 64'(strict_valid_cycles), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
